// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank responder: command codes, FSM states and
// a one-hot validity helper.
package dram_pkg;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_REF = 2'b11;

  // Widest select vector the validity helper has to handle (row_sel).
  localparam int unsigned MaxSelWidth = 128;

  typedef enum logic [2:0] {
    StIdle,
    StActWait,
    StRdWait,
    StRdShift,
    StWrShift,
    StRefWait,
    StAck
  } state_e;

  function automatic logic onehot_valid(input logic [MaxSelWidth-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/dram_onehot2bin.sv
// One-hot to binary index converter with a flag that is set only for exactly one hot bit.
module dram_onehot2bin
  import dram_pkg::*;
#(
  parameter int unsigned Width = 8,
  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] onehot_i,
  output logic [IdxW-1:0]  index_o,
  output logic             valid_o
);

  assign valid_o = onehot_valid(MaxSelWidth'(onehot_i));

  always_comb begin
    index_o = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (onehot_i[i]) index_o |= IdxW'(i);
    end
  end

endmodule

// File: rtl/dram_bank_responder.sv
// Device-side DRAM model: tracks open rows per bank, applies activate/refresh latency
// and moves bytes over a serial data line, MSB first.
module dram_bank_responder
  import dram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned T_RFC        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic                    bank_rw,
  input  logic                    buf_rw,
  input  logic                    dram_data_i,
  output logic                    dram_data_o,
  output logic                    dram_data_oe,
  output logic                    cmd_ack,
  output logic [NUM_OF_BANKS-1:0] open_rows,
  output logic                    cmd_err
);

  localparam int unsigned BankW  = $clog2(NUM_OF_BANKS);
  localparam int unsigned RowW   = $clog2(NUM_OF_ROWS);
  localparam int unsigned ColW   = $clog2(NUM_OF_COLS);
  localparam int unsigned AddrW  = BankW + RowW + ColW;
  localparam int unsigned CntMax = (T_RFC > DATA_WIDTH) ? T_RFC : DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  logic [BankW-1:0] bank_idx;
  logic [RowW-1:0]  row_idx;
  logic [ColW-1:0]  col_idx;
  logic             bank_ok, row_ok, col_ok;

  dram_onehot2bin #(.Width(NUM_OF_BANKS)) u_bank_dec (
    .onehot_i(bank_sel),
    .index_o (bank_idx),
    .valid_o (bank_ok)
  );

  dram_onehot2bin #(.Width(NUM_OF_ROWS)) u_row_dec (
    .onehot_i(row_sel),
    .index_o (row_idx),
    .valid_o (row_ok)
  );

  dram_onehot2bin #(.Width(NUM_OF_COLS)) u_col_dec (
    .onehot_i(col_sel),
    .index_o (col_idx),
    .valid_o (col_ok)
  );

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [BankW-1:0]      bank_q;
  logic [RowW-1:0]       row_q;
  logic [AddrW-1:0]      addr_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [RowW-1:0]       row_idx_q [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0] mem [2**AddrW];

  logic             cap_err;
  logic [AddrW-1:0] cap_addr;

  function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign cap_addr = {bank_idx, row_idx_q[bank_idx], col_idx};

  always_comb begin
    cap_err = !bank_ok;
    case (cmd)
      CMD_ACT:        cap_err = cap_err || !row_ok;
      CMD_RD, CMD_WR: cap_err = cap_err || !col_ok || !open_rows[bank_idx] ||
                                (bank_rw != (cmd == CMD_RD));
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bank_q       <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      shift_q      <= '0;
      cmd_ack      <= 1'b0;
      dram_data_o  <= 1'b0;
      dram_data_oe <= 1'b0;
      open_rows    <= '0;
      cmd_err      <= 1'b0;
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) row_idx_q[b] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_req) begin
            cnt_q  <= '0;
            bank_q <= bank_idx;
            row_q  <= row_idx;
            addr_q <= cap_addr;
            if (cap_err) begin
              cmd_err <= 1'b1;
              cmd_ack <= 1'b1;
              state_q <= StAck;
            end else begin
              case (cmd)
                CMD_ACT: state_q <= StActWait;
                CMD_RD: begin
                  shift_q <= mem[cap_addr];
                  state_q <= StRdWait;
                end
                CMD_WR:  state_q <= StWrShift;
                default: begin
                  open_rows <= '0;
                  state_q   <= StRefWait;
                end
              endcase
            end
          end
        end
        StActWait: begin
          if (cnt_q == CntW'(T_RCD - 1)) begin
            open_rows[bank_q] <= 1'b1;
            row_idx_q[bank_q] <= row_q;
            cmd_ack           <= 1'b1;
            state_q           <= StAck;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        StRefWait: begin
          if (cnt_q == CntW'(T_RFC - 1)) begin
            cmd_ack <= 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        StRdWait: begin
          if (buf_rw) begin
            dram_data_oe <= 1'b1;
            dram_data_o  <= shift_q[DATA_WIDTH-1];
            shift_q      <= shift_q << 1;
            state_q      <= StRdShift;
          end
        end
        StRdShift: begin
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            dram_data_oe <= 1'b0;
            dram_data_o  <= 1'b0;
            cmd_ack      <= 1'b1;
            state_q      <= StAck;
          end else begin
            cnt_q       <= cnt_inc(cnt_q);
            dram_data_o <= shift_q[DATA_WIDTH-1];
            shift_q     <= shift_q << 1;
          end
        end
        StWrShift: begin
          shift_q <= {shift_q[DATA_WIDTH-2:0], dram_data_i};
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            cmd_ack <= 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        StAck: begin
          if (!cmd_req) begin
            cmd_ack <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The byte lands together with its last serial sample; reset aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StWrShift && cnt_q == CntW'(DATA_WIDTH - 1)) begin
      mem[addr_q] <= {shift_q[DATA_WIDTH-2:0], dram_data_i};
    end
  end

endmodule

// File: tb/tb_dram_bank_responder.sv
// Self-checking bench for dram_bank_responder: directed steps plus randomized commands
// checked against a command-level model of banks, rows and storage.
module tb_dram_bank_responder;
  import dram_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_req = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic [7:0]   bank_sel = '0;
  logic [127:0] row_sel = '0;
  logic [7:0]   col_sel = '0;
  logic         bank_rw = 1'b0;
  logic         buf_rw = 1'b0;
  logic         dram_data_i = 1'b0;
  logic         dram_data_o, dram_data_oe, cmd_ack, cmd_err;
  logic [7:0]   open_rows;

  dram_bank_responder dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_req     (cmd_req),
    .cmd         (cmd),
    .bank_sel    (bank_sel),
    .row_sel     (row_sel),
    .col_sel     (col_sel),
    .bank_rw     (bank_rw),
    .buf_rw      (buf_rw),
    .dram_data_i (dram_data_i),
    .dram_data_o (dram_data_o),
    .dram_data_oe(dram_data_oe),
    .cmd_ack     (cmd_ack),
    .open_rows   (open_rows),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] model_mem [int];
  bit   [7:0] m_open = '0;
  int         m_row [8];
  bit         m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] bsel, input logic [127:0] rsel,
                         input logic [7:0] csel, input logic rw, input logic [7:0] wdata,
                         input int buf_delay);
    int b, r, col, addr, exp_lat, exp_first, lat, oe_n, oe_first;
    bit err, is_rd;
    logic [7:0] rbits, open_cap, exp_open_cap;
    b     = lowest(128'(bsel));
    r     = lowest(rsel);
    col   = lowest(128'(csel));
    is_rd = (c == CMD_RD);
    err   = ($countones(bsel) != 1);
    if (c == CMD_ACT) err = err || ($countones(rsel) != 1);
    if (c == CMD_RD || c == CMD_WR)
      err = err || ($countones(csel) != 1) || !m_open[b] || (rw != is_rd);
    addr      = b * 1024 + m_row[b] * 8 + col;
    exp_first = (buf_delay < 1) ? 1 : buf_delay;
    if (err) exp_lat = 0;
    else if (c == CMD_ACT) exp_lat = 3;
    else if (c == CMD_REF) exp_lat = 16;
    else if (c == CMD_WR) exp_lat = 8;
    else exp_lat = exp_first + 8;
    exp_open_cap = (c == CMD_REF && !err) ? 8'h00 : m_open;

    @(negedge clk);
    cmd_req = 1'b1; cmd = c; bank_sel = bsel; row_sel = rsel; col_sel = csel;
    bank_rw = rw; buf_rw = (buf_delay <= 0);
    lat = -1; oe_n = 0; oe_first = -1; rbits = '0; open_cap = '0;
    for (int n = 0; n < 64 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) open_cap = open_rows;
      if (dram_data_oe === 1'b1) begin
        if (oe_first < 0) oe_first = n;
        if (oe_n < 8) rbits[7-oe_n] = dram_data_o;
        oe_n++;
      end
      if (cmd_ack === 1'b1) lat = n;
      dram_data_i = (n < 8) ? wdata[7-n] : 1'b0;
      buf_rw = (n + 1 >= buf_delay);
    end
    cmd_req = 1'b0;
    check("ack_latency", lat, exp_lat);
    check("open_rows_after_capture", open_cap, exp_open_cap);
    check("oe_cycles", oe_n, (is_rd && !err) ? 8 : 0);
    if (is_rd && !err) begin
      check("oe_first_cycle", oe_first, exp_first);
      if (model_mem.exists(addr)) check("read_data", rbits, model_mem[addr]);
    end

    if (err) m_err = 1'b1;
    else if (c == CMD_ACT) begin m_open[b] = 1'b1; m_row[b] = r; end
    else if (c == CMD_REF) m_open = '0;
    else if (c == CMD_WR) model_mem[addr] = wdata;

    @(negedge clk);
    buf_rw = 1'b0; dram_data_i = 1'b0;
    check("ack_drop", cmd_ack, 1'b0);
    check("open_rows", open_rows, m_open);
    check("cmd_err", cmd_err, m_err);
  endtask

  initial begin
    logic [127:0] rs;
    logic [7:0]   bs, cs;
    logic [1:0]   c;
    logic         rw;
    int           k;
    for (int i = 0; i < 8; i++) m_row[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ack", cmd_ack, 1'b0);
    check("rst_oe", dram_data_oe, 1'b0);
    check("rst_data_o", dram_data_o, 1'b0);
    check("rst_open_rows", open_rows, 8'h00);
    check("rst_cmd_err", cmd_err, 1'b0);
    rst = 1'b0;

    rs = '0; rs[37] = 1'b1;
    run_cmd(CMD_ACT, 8'h04, rs, 8'h00, 1'b0, 8'h00, 0);
    check("act_open_rows", open_rows, 8'h04);
    run_cmd(CMD_WR, 8'h04, '0, 8'h20, 1'b0, 8'hA5, 0);
    run_cmd(CMD_RD, 8'h04, '0, 8'h20, 1'b1, 8'h00, 0);
    run_cmd(CMD_RD, 8'h04, '0, 8'h20, 1'b1, 8'h00, 6);
    run_cmd(CMD_RD, 8'h20, '0, 8'h01, 1'b1, 8'h00, 0);
    check("bad_read_err", cmd_err, 1'b1);

    for (int b = 0; b < 8; b++) begin
      rs = '0; rs[b*5] = 1'b1;
      run_cmd(CMD_ACT, 8'(1) << b, rs, 8'h00, 1'b0, 8'h00, 0);
    end
    check("all_open", open_rows, 8'hFF);
    run_cmd(CMD_REF, 8'h01, '0, 8'h00, 1'b0, 8'h00, 0);

    // Reset in the middle of a write: after bits 7..5 are sampled.
    rs = '0; rs[37] = 1'b1;
    run_cmd(CMD_ACT, 8'h04, rs, 8'h00, 1'b0, 8'h00, 0);
    @(negedge clk);
    cmd_req = 1'b1; cmd = CMD_WR; bank_sel = 8'h04; col_sel = 8'h20; bank_rw = 1'b0;
    @(negedge clk); dram_data_i = 1'b0;
    @(negedge clk); dram_data_i = 1'b0;
    @(negedge clk); dram_data_i = 1'b1;
    @(negedge clk); dram_data_i = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("abort_cmd_ack", cmd_ack, 1'b0);
    check("abort_oe", dram_data_oe, 1'b0);
    check("abort_data_o", dram_data_o, 1'b0);
    check("abort_open_rows", open_rows, 8'h00);
    check("abort_cmd_err", cmd_err, 1'b0);
    rst = 1'b0; cmd_req = 1'b0; dram_data_i = 1'b0;
    m_open = '0; m_err = 1'b0;
    for (int i = 0; i < 8; i++) m_row[i] = 0;
    @(negedge clk);
    run_cmd(CMD_ACT, 8'h04, rs, 8'h00, 1'b0, 8'h00, 0);
    run_cmd(CMD_RD, 8'h04, '0, 8'h20, 1'b1, 8'h00, 2);

    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 9);
      c  = (k < 3) ? CMD_ACT : (k < 6) ? CMD_RD : (k < 9) ? CMD_WR : CMD_REF;
      bs = 8'(1) << $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) bs = 8'($urandom);
      rs = '0; rs[$urandom_range(0, 127)] = 1'b1;
      cs = 8'(1) << $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) cs = 8'($urandom);
      rw = (c == CMD_RD);
      if ($urandom_range(0, 19) == 0) rw = !rw;
      run_cmd(c, bs, rs, cs, rw, 8'($urandom), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
